// File: rtl/boton_sensor_ar.sv
// boton_sensor_ar: debounce/qualify filter for one button or sensor input, with edge strobes.
// Define AR_SYNC_EN to add a two-flop synchronizer in front of the filter (+2 clocks latency).
module boton_sensor_ar #(
  parameter int STABLE_CYCLES = 10000,
  parameter bit SENSOR_MODE = 1'b0,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s, diff, fast_fall, out_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
`ifdef AR_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    sync <= reset ? 2'b00 : {sync[0], sig_in};
  assign s = sync[1];
`else
  assign s = sig_in;
`endif
  // in sensor mode a drop to 0 bypasses the qualification count
  always_comb begin
    diff = s != sig_out;
    fast_fall = SENSOR_MODE && !s;
    out_nxt = (diff && (fast_fall || cnt == LAST)) ? s : sig_out;
    cnt_nxt = (diff && !fast_fall && cnt != LAST) ? cnt + CNT_W'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_out <= 1'b0;
      cnt <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sig_out <= out_nxt;
      cnt <= cnt_nxt;
      rise_pulse <= out_nxt & ~sig_out;
      fall_pulse <= ~out_nxt & sig_out;
    end
  end
endmodule

// File: tb/tb_boton_sensor_ar.sv
// tb_boton_sensor_ar: scoreboard bench for button (N=4), sensor (N=4) and button (N=1) filters.
module tb_boton_sensor_ar;
`ifdef AR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, b = 1'b0, sn = 1'b0;
  logic o[3], r[3], f[3];
  int total = 0, bad = 0;
  logic [8:0] q[$];
  logic m_o[3] = '{1'b0, 1'b0, 1'b0};
  logic m_s1[3] = '{1'b0, 1'b0, 1'b0};
  logic m_s2[3] = '{1'b0, 1'b0, 1'b0};
  int m_run[3] = '{0, 0, 0};
  int n_of[3] = '{4, 4, 1};
  bit sm_of[3] = '{1'b0, 1'b1, 1'b0};
  logic [2:0] obs[3];
  always #5 clk = ~clk;
  boton_sensor_ar #(.STABLE_CYCLES(4), .SENSOR_MODE(1'b0)) u_btn (
    .clk(clk), .reset(reset), .sig_in(b), .sig_out(o[0]), .rise_pulse(r[0]), .fall_pulse(f[0]));
  boton_sensor_ar #(.STABLE_CYCLES(4), .SENSOR_MODE(1'b1)) u_sen (
    .clk(clk), .reset(reset), .sig_in(sn), .sig_out(o[1]), .rise_pulse(r[1]), .fall_pulse(f[1]));
  boton_sensor_ar #(.STABLE_CYCLES(1), .SENSOR_MODE(1'b0)) u_one (
    .clk(clk), .reset(reset), .sig_in(b), .sig_out(o[2]), .rise_pulse(r[2]), .fall_pulse(f[2]));
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  // reference: counts consecutive samples differing from the output
  task automatic step(input logic rr, input logic bb, input logic ss);
    logic in_v[3];
    logic [8:0] e;
    logic sv, no;
    reset = rr;
    b = bb;
    sn = ss;
    in_v = '{bb, ss, bb};
    e = '0;
    for (int i = 0; i < 3; i++) begin
      if (rr) begin
        m_o[i] = 1'b0;
        m_s1[i] = 1'b0;
        m_s2[i] = 1'b0;
        m_run[i] = 0;
      end else begin
`ifdef AR_SYNC_EN
        sv = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = in_v[i];
`else
        sv = in_v[i];
`endif
        no = m_o[i];
        if (sv == m_o[i]) m_run[i] = 0;
        else if (sm_of[i] && !sv) begin
          no = 1'b0;
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == n_of[i]) begin
            no = sv;
            m_run[i] = 0;
          end
        end
        e[3*i+:3] = {no, no & ~m_o[i], ~no & m_o[i]};
        m_o[i] = no;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    for (int i = 0; i < 3; i++) begin
      obs[i] = {o[i], r[i], f[i]};
      check($sformatf("cycle_ch%0d", i), obs[i], e[3*i+:3]);
    end
  endtask
  initial begin
    repeat (2) step(1, 0, 0);
    check("reset_btn", obs[0], 3'b000);
    check("reset_sen", obs[1], 3'b000);
    repeat (20) step(0, 0, 0);
    check("idle_btn", obs[0], 3'b000);
    repeat (SL + 1) step(0, 1, 0);
    check("n1_rise", obs[2], 3'b110);
    repeat (2) step(0, 1, 0);
    check("btn_rise_early", obs[0], 3'b000);
    step(0, 1, 0);
    check("btn_rise", obs[0], 3'b110);
    step(0, 1, 0);
    check("btn_rise_pulse_end", obs[0], 3'b100);
    repeat (SL + 1) step(0, 0, 0);
    check("n1_fall", obs[2], 3'b001);
    repeat (2) step(0, 0, 0);
    check("btn_fall_early", obs[0], 3'b100);
    step(0, 0, 0);
    check("btn_fall", obs[0], 3'b001);
    step(0, 0, 0);
    check("btn_fall_pulse_end", obs[0], 3'b000);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    repeat (3 + SL) step(0, 1, 0);
    check("bounce_hold", obs[0], 3'b000);
    step(0, 1, 0);
    check("bounce_rise", obs[0], 3'b110);
    repeat (4 + SL) step(0, 1, 1);
    check("sen_rise", obs[1], 3'b110);
    step(0, 1, 0);
    repeat (SL) step(0, 1, 1);
    check("sen_fast_fall", obs[1], 3'b001);
    repeat (5) step(0, 1, 0);
    check("sen_low", obs[1], 3'b000);
    repeat (3) step(0, 1, 1);
    repeat (3 + SL) step(0, 1, 0);
    check("sen_glitch", obs[1], 3'b000);
    step(1, 1, 0);
    check("reset_out_high", obs[0], 3'b000);
    repeat (2 + SL) step(0, 1, 0);
    step(1, 1, 0);
    check("reset_mid_count", obs[0], 3'b000);
    repeat (3 + SL) step(0, 1, 0);
    check("release_hold", obs[0], 3'b000);
    step(0, 1, 0);
    check("release_rise", obs[0], 3'b110);
    for (int k = 0; k < 60; k++) step(k % 17 == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
